// File: rtl/axi_read_handler_if.sv
// AXI4-Lite read-channel bundle (AR and R) between the read handler and an AXI-Lite slave.
// The master modport is the handler side; the slave modport is the memory/peripheral side.
interface axi_read_handler_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output araddr, arprot, arvalid, rready,
      input  arready, rdata, rresp, rvalid
   );

   modport slave (
      input  araddr, arprot, arvalid, rready,
      output arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_read_handler.sv
// AXI4-Lite read initiator: one user request becomes one AR/R transaction, one at a time.
// Result data/response are held until the next completion; read_valid pulses for one cycle.
module axi_read_handler #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   input  logic                  start_read,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic [1:0]            read_resp,
   output logic                  read_valid,
   output logic                  read_error,
   axi_read_handler_if.master    s_axil
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] araddr_reg, araddr_next;
   logic                  arvalid_reg, arvalid_next;
   logic [DATA_WIDTH-1:0] data_reg, data_next;
   logic [1:0]            resp_reg, resp_next;
   logic                  error_reg, error_next;
   logic                  valid_reg, valid_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         araddr_reg  <= '0;
         arvalid_reg <= 1'b0;
         data_reg    <= '0;
         resp_reg    <= 2'b00;
         error_reg   <= 1'b0;
         valid_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         araddr_reg  <= araddr_next;
         arvalid_reg <= arvalid_next;
         data_reg    <= data_next;
         resp_reg    <= resp_next;
         error_reg   <= error_next;
         valid_reg   <= valid_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      araddr_next  = araddr_reg;
      arvalid_next = arvalid_reg;
      data_next    = data_reg;
      resp_next    = resp_reg;
      error_next   = error_reg;
      valid_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start_read) begin
               araddr_next  = read_addr;
               arvalid_next = 1'b1;
               state_next   = ADDR;
            end
         end
         ADDR: begin
            // rvalid seen here precedes the address handshake and is never taken as data.
            if (arvalid_reg && s_axil.arready) begin
               arvalid_next = 1'b0;
               state_next   = DATA;
            end
         end
         DATA: begin
            if (s_axil.rvalid) begin
               data_next  = s_axil.rdata;
               resp_next  = s_axil.rresp;
               error_next = (s_axil.rresp != 2'b00);
               valid_next = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ready and rready decode only the state register, so no input reaches an output combinationally.
   assign ready          = (state_reg == IDLE);
   assign s_axil.rready  = (state_reg == ADDR) || (state_reg == DATA);
   assign s_axil.araddr  = araddr_reg;
   assign s_axil.arvalid = arvalid_reg;
   assign s_axil.arprot  = 3'b000;

   assign read_data  = data_reg;
   assign read_resp  = resp_reg;
   assign read_error = error_reg;
   assign read_valid = valid_reg;
endmodule

// File: tb/tb_axi_read_handler.sv
// Directed bench for axi_read_handler with a small AXI-Lite slave model and a result scoreboard.
module tb_axi_read_handler;
   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          err;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] read_addr;
   logic          start_read;
   logic          ready;
   logic [DW-1:0] read_data;
   logic [1:0]    read_resp;
   logic          read_valid;
   logic          read_error;

   axi_read_handler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axil ();

   axi_read_handler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .read_addr  (read_addr),
      .start_read (start_read),
      .ready      (ready),
      .read_data  (read_data),
      .read_resp  (read_resp),
      .read_valid (read_valid),
      .read_error (read_error),
      .s_axil     (axil)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave model: fixed-latency memory with bench-controlled arready, response code and data delay.
   logic [DW-1:0] mem [32];
   logic          arready_v;
   logic [1:0]    resp_cfg;
   int            r_delay;
   logic          slave_flush;
   logic          rvalid_q;
   logic [DW-1:0] rdata_q;
   logic [1:0]    rresp_q;
   logic          pend;
   int            rcnt;

   assign axil.arready = arready_v;
   assign axil.rvalid  = rvalid_q;
   assign axil.rdata   = rdata_q;
   assign axil.rresp   = rresp_q;

   always @(posedge clk) begin
      if (slave_flush) begin
         pend     <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         if (rvalid_q && axil.rready) rvalid_q <= 1'b0;
         if (axil.arvalid && axil.arready) begin
            rdata_q <= mem[axil.araddr];
            rresp_q <= resp_cfg;
            if (r_delay == 0) rvalid_q <= 1'b1;
            else begin
               pend <= 1'b1;
               rcnt <= r_delay - 1;
            end
         end else if (pend) begin
            if (rcnt == 0) begin
               rvalid_q <= 1'b1;
               pend     <= 1'b0;
            end else rcnt <= rcnt - 1;
         end
      end
   end

   int total = 0;
   int bad = 0;
   int valid_cnt = 0;
   exp_t sb[$];

   always @(negedge clk) if (read_valid === 1'b1) valid_cnt++;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic push_exp(input logic [AW-1:0] a, input logic [1:0] r);
      exp_t e;
      e.data = mem[a];
      e.resp = r;
      e.err  = (r != 2'b00);
      sb.push_back(e);
   endtask

   // Presents start_read for exactly one rising edge; returns at the following falling edge.
   task automatic start(input logic [AW-1:0] a);
      read_addr  = a;
      start_read = 1'b1;
      step();
      start_read = 1'b0;
   endtask

   // lat0 = edges already elapsed counting the start edge; waits for read_valid and scores it.
   task automatic wait_done(input string tag, input int lat0, input int exp_lat);
      int   lat;
      exp_t e;
      lat = lat0;
      while (read_valid !== 1'b1 && lat < 40) begin
         step();
         lat++;
      end
      chk({tag, "_valid"}, 64'(read_valid), 64'(1));
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_data"}, 64'(read_data), 64'(e.data));
         chk({tag, "_resp"}, 64'(read_resp), 64'(e.resp));
         chk({tag, "_error"}, 64'(read_error), 64'(e.err));
      end
      chk({tag, "_ready"}, 64'(ready), 64'(1));
   endtask

   initial begin
      int snap;
      for (int i = 0; i < 32; i++) mem[i] = 32'hA5000000 ^ (i * 32'h00010203);
      mem[1] = 32'hDEADBEEF;
      mem[2] = 32'hCAFEF00D;
      mem[3] = 32'h12345678;

      rst_n       = 1'b0;
      start_read  = 1'b0;
      read_addr   = '0;
      arready_v   = 1'b1;
      resp_cfg    = 2'b00;
      r_delay     = 0;
      slave_flush = 1'b1;
      repeat (3) step();

      // Reset state
      chk("rst_ready", 64'(ready), 64'(1));
      chk("rst_arvalid", 64'(axil.arvalid), 64'(0));
      chk("rst_araddr", 64'(axil.araddr), 64'(0));
      chk("rst_rready", 64'(axil.rready), 64'(0));
      chk("rst_arprot", 64'(axil.arprot), 64'(0));
      chk("rst_read_valid", 64'(read_valid), 64'(0));
      chk("rst_read_data", 64'(read_data), 64'(0));
      chk("rst_read_resp", 64'(read_resp), 64'(0));
      chk("rst_read_error", 64'(read_error), 64'(0));
      rst_n       = 1'b1;
      slave_flush = 1'b0;
      step();
      $display("txn reset: checks done");

      // Zero-wait read of address 1
      push_exp(5'd1, 2'b00);
      start(5'd1);
      chk("zw_ready_low", 64'(ready), 64'(0));
      chk("zw_arvalid", 64'(axil.arvalid), 64'(1));
      wait_done("zw", 1, 3);
      step();
      chk("zw_pulse_one_cycle", 64'(read_valid), 64'(0));
      $display("txn zero-wait addr=1 data=%h", read_data);

      // arready stalled four cycles
      arready_v = 1'b0;
      push_exp(5'd5, 2'b00);
      start(5'd5);
      for (int i = 0; i < 4; i++) begin
         chk("stall_arvalid", 64'(axil.arvalid), 64'(1));
         chk("stall_araddr", 64'(axil.araddr), 64'(5));
         step();
      end
      arready_v = 1'b1;
      step();
      chk("stall_arvalid_drop", 64'(axil.arvalid), 64'(0));
      wait_done("stall", 6, 7);
      step();
      $display("txn arready-stall addr=5 data=%h", read_data);

      // SLVERR response, held afterwards
      resp_cfg = 2'b10;
      push_exp(5'd3, 2'b10);
      start(5'd3);
      wait_done("err", 1, 3);
      resp_cfg = 2'b00;
      step();
      step();
      chk("err_hold_valid", 64'(read_valid), 64'(0));
      chk("err_hold_error", 64'(read_error), 64'(1));
      chk("err_hold_resp", 64'(read_resp), 64'(2));
      chk("err_hold_data", 64'(read_data), 64'(32'h12345678));
      $display("txn slverr addr=3 resp=%0d", read_resp);

      // start_read during ADDR and DATA is ignored
      snap = valid_cnt;
      arready_v = 1'b0;
      r_delay   = 2;
      push_exp(5'd7, 2'b00);
      start(5'd7);
      read_addr  = 5'd9;
      start_read = 1'b1;
      step();
      chk("ign_araddr_addr", 64'(axil.araddr), 64'(7));
      chk("ign_arvalid", 64'(axil.arvalid), 64'(1));
      read_addr = 5'd10;
      arready_v = 1'b1;
      step();
      chk("ign_arvalid_drop", 64'(axil.arvalid), 64'(0));
      chk("ign_araddr_data", 64'(axil.araddr), 64'(7));
      read_addr = 5'd11;
      step();
      start_read = 1'b0;
      wait_done("ign", 4, 6);
      repeat (3) step();
      chk("ign_one_valid", 64'(valid_cnt - snap), 64'(1));
      chk("ign_no_new_ar", 64'(axil.arvalid), 64'(0));
      chk("ign_idle", 64'(ready), 64'(1));
      r_delay = 0;
      $display("txn ignored-starts addr=7 data=%h", read_data);

      // Back-to-back: second start in the read_valid cycle of the first
      push_exp(5'd1, 2'b00);
      push_exp(5'd2, 2'b00);
      start(5'd1);
      wait_done("b2b1", 1, 3);
      start(5'd2);
      chk("b2b_accepted", 64'(axil.arvalid), 64'(1));
      chk("b2b_araddr", 64'(axil.araddr), 64'(2));
      wait_done("b2b2", 1, 3);
      step();
      $display("txn back-to-back addr=1,2 data=%h", read_data);

      // Reset while in DATA; late rvalid afterwards must not complete
      r_delay = 5;
      start(5'd4);
      step();
      chk("mid_in_data_rready", 64'(axil.rready), 64'(1));
      chk("mid_in_data_arvalid", 64'(axil.arvalid), 64'(0));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 64'(ready), 64'(1));
      chk("mid_rst_rready", 64'(axil.rready), 64'(0));
      chk("mid_rst_data", 64'(read_data), 64'(0));
      chk("mid_rst_araddr", 64'(axil.araddr), 64'(0));
      chk("mid_rst_valid", 64'(read_valid), 64'(0));
      snap = valid_cnt;
      step();
      rst_n = 1'b1;
      repeat (8) step();
      chk("late_rvalid_ignored", 64'(valid_cnt - snap), 64'(0));
      chk("late_rvalid_data", 64'(read_data), 64'(0));
      chk("late_rvalid_ready", 64'(ready), 64'(1));
      slave_flush = 1'b1;
      step();
      slave_flush = 1'b0;
      r_delay = 0;
      $display("txn reset-in-data addr=4 abandoned");

      // Recovery read
      push_exp(5'd6, 2'b00);
      start(5'd6);
      wait_done("recover", 1, 3);
      step();
      chk("sb_drained", 64'(sb.size()), 64'(0));
      $display("txn recovery addr=6 data=%h", read_data);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
